// File: rtl/descrambler.sv
// Receive-side PCIe Gen1/Gen2 lane descrambler: strips the X^16+X^5+X^4+X^3+1
// keystream, re-aligns the LFSR on COM, pauses it on SKP, and tracks lock.
module descrambler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       disable_i,
  input  logic       resync_i,
  output logic [7:0] data_o,
  output logic       k_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       sync_o,
  output logic [7:0] skp_cnt_o
);

  localparam logic [15:0] SEED    = 16'hFFFF;
  localparam logic [7:0]  COM_SYM = 8'hBC;
  localparam logic [7:0]  SKP_SYM = 8'h1C;

  typedef enum logic {UNSYNC, SYNC} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_adv;
  logic [7:0]  key;
  logic        accept;
  logic        is_com;
  logic        is_skp;

  // One Galois step of the transmit polynomial.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:5], q[4] ^ q[15], q[3] ^ q[15], q[2] ^ q[15], q[1], q[0], q[15]};
  endfunction

  // Key bit i is the LFSR MSB before step i; the byte consumes eight steps.
  always_comb begin
    logic [15:0] q;
    q   = lfsr;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = q[15];
      q      = lfsr_step(q);
    end
    lfsr_adv = q;
  end

  // The output register can take a new symbol when empty or being drained.
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign is_com  = k_i && (data_i == COM_SYM);
  assign is_skp  = k_i && (data_i == SKP_SYM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= UNSYNC;
      lfsr      <= SEED;
      valid_o   <= 1'b0;
      data_o    <= '0;
      k_o       <= 1'b0;
      sync_o    <= 1'b0;
      skp_cnt_o <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment to the
      // same register in this block overrides the default drain below.
      if (ready_o) valid_o <= 1'b0;

      if (accept) begin
        unique case (state)
          UNSYNC: begin
            // Until aligned, everything but COM is discarded.
            if (is_com) begin
              valid_o <= 1'b1;
              data_o  <= data_i;
              k_o     <= 1'b1;
              lfsr    <= SEED;
              state   <= SYNC;
              sync_o  <= 1'b1;
            end
          end
          SYNC: begin
            valid_o <= 1'b1;
            k_o     <= k_i;
            if (is_com) begin
              data_o <= data_i;
              lfsr   <= SEED;
            end else if (is_skp) begin
              data_o    <= data_i;
              skp_cnt_o <= skp_cnt_o + 8'd1;
            end else if (k_i) begin
              data_o <= data_i;
              lfsr   <= lfsr_adv;
            end else begin
              data_o <= disable_i ? data_i : (data_i ^ key);
              lfsr   <= lfsr_adv;
            end
          end
          default: ;
        endcase
      end

      // Loss of lock wins over a COM arriving in the same cycle.
      if (resync_i) begin
        state  <= UNSYNC;
        sync_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for descrambler: reference keystream, SKP pause, lock
// acquisition/loss, backpressure, disable and asynchronous reset.
module tb_descrambler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] data_i;
  logic       k_i;
  logic       valid_i;
  logic       ready_o;
  logic       disable_i;
  logic       resync_i;
  logic [7:0] data_o;
  logic       k_o;
  logic       valid_o;
  logic       ready_i;
  logic       sync_o;
  logic [7:0] skp_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference keystream for the first 16 D bytes after a COM (seed FFFF).
  logic [7:0] exp_key [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                               8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

  descrambler dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .k_i       (k_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .disable_i (disable_i),
    .resync_i  (resync_i),
    .data_o    (data_o),
    .k_o       (k_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sync_o    (sync_o),
    .skp_cnt_o (skp_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic k);
    valid_i = 1'b1;
    data_i  = d;
    k_i     = k;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic k);
    check({tag, ".valid"}, 16'(valid_o), 16'(v));
    if (v) begin
      check({tag, ".data"}, 16'(data_o), 16'(d));
      check({tag, ".k"},    16'(k_o),    16'(k));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"}, 16'(valid_o),   16'h0);
    check({tag, ".data"},  16'(data_o),    16'h0);
    check({tag, ".k"},     16'(k_o),       16'h0);
    check({tag, ".sync"},  16'(sync_o),    16'h0);
    check({tag, ".skp"},   16'(skp_cnt_o), 16'h0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    data_i    = '0;
    k_i       = 1'b0;
    valid_i   = 1'b0;
    disable_i = 1'b0;
    resync_i  = 1'b0;
    ready_i   = 1'b1;

    // Reset state
    tick();
    tick();
    check_zero_outputs("reset");
    check("reset.ready", 16'(ready_o), 16'h1);
    rst_ni = 1'b1;
    tick();

    // D bytes and a SKP before lock are dropped
    send(8'h00, 1'b0);
    check_out("unsync_d0", 1'b0, 8'h00, 1'b0);
    check("unsync_d0.sync", 16'(sync_o), 16'h0);
    send(8'h1C, 1'b1);
    check_out("unsync_skp", 1'b0, 8'h00, 1'b0);
    check("unsync_skp.cnt", 16'(skp_cnt_o), 16'h0);

    // COM acquires lock; 16 zero bytes reveal the reference keystream
    send(8'hBC, 1'b1);
    check_out("com1", 1'b1, 8'hBC, 1'b1);
    check("com1.sync", 16'(sync_o), 16'h1);
    for (int i = 0; i < 16; i++) begin
      send(8'h00, 1'b0);
      check_out($sformatf("ref%0d", i), 1'b1, exp_key[i], 1'b0);
    end
    tick();
    check("idle.valid", 16'(valid_o), 16'h0);

    // SKP after byte 3 pauses the LFSR and bumps the counter
    send(8'hBC, 1'b1);
    check_out("com2", 1'b1, 8'hBC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 1'b0);
      check_out($sformatf("skpseq%0d", i), 1'b1, exp_key[i], 1'b0);
    end
    send(8'h1C, 1'b1);
    check_out("skp", 1'b1, 8'h1C, 1'b1);
    check("skp.cnt", 16'(skp_cnt_o), 16'h1);
    for (int i = 3; i < 16; i++) begin
      send(8'h00, 1'b0);
      check_out($sformatf("skpseq%0d", i), 1'b1, exp_key[i], 1'b0);
    end
    tick();

    // Backpressure: output holds and nothing is lost or repeated
    send(8'hBC, 1'b1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check_out("bp_pre", 1'b1, 8'h17, 1'b0);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h00;
    k_i     = 1'b0;
    #1;
    check("bp.ready_o", 16'(ready_o), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 8'h17, 1'b0);
      check($sformatf("bp_hold%0d.ready_o", i), 16'(ready_o), 16'h0);
    end
    ready_i = 1'b1;
    send(8'h00, 1'b0);
    check_out("bp_post0", 1'b1, 8'hC0, 1'b0);
    send(8'h00, 1'b0);
    check_out("bp_post1", 1'b1, 8'h14, 1'b0);
    tick();

    // Disable: bytes pass through while the LFSR keeps advancing
    send(8'hBC, 1'b1);
    disable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(8'h5A, 1'b0);
      check_out($sformatf("dis%0d", i), 1'b1, 8'h5A, 1'b0);
    end
    disable_i = 1'b0;
    send(8'h00, 1'b0);
    check_out("dis_off0", 1'b1, 8'h14, 1'b0);
    send(8'h00, 1'b0);
    check_out("dis_off1", 1'b1, 8'hB2, 1'b0);

    // Resync pulse drops lock; counter holds; relock on next COM
    resync_i = 1'b1;
    tick();
    resync_i = 1'b0;
    check("resync.sync", 16'(sync_o), 16'h0);
    check("resync.cnt", 16'(skp_cnt_o), 16'h1);
    send(8'h00, 1'b0);
    check_out("resync_drop", 1'b0, 8'h00, 1'b0);
    check("resync_drop.sync", 16'(sync_o), 16'h0);
    send(8'hBC, 1'b1);
    check_out("relock_com", 1'b1, 8'hBC, 1'b1);
    check("relock.sync", 16'(sync_o), 16'h1);
    send(8'h00, 1'b0);
    check_out("relock_d0", 1'b1, 8'hFF, 1'b0);
    send(8'h00, 1'b0);
    check_out("relock_d1", 1'b1, 8'h17, 1'b0);

    // Asynchronous reset mid-stream, between clock edges
    valid_i = 1'b1;
    data_i  = 8'h00;
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    send(8'h00, 1'b0);
    check_out("post_rst_drop", 1'b0, 8'h00, 1'b0);
    send(8'hBC, 1'b1);
    check_out("post_rst_com", 1'b1, 8'hBC, 1'b1);
    send(8'h00, 1'b0);
    check_out("post_rst_d0", 1'b1, 8'hFF, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/descrambler.md
# descrambler

Receive-side byte descrambler for one PCIe Gen1/Gen2 lane; the inverse of the transmit scrambler. It sits between the 8b/10b decoder and lane deskew/ordered-set logic. It recovers data bytes by XOR with the X^16+X^5+X^4+X^3+1 LFSR sequence, and keeps that LFSR aligned to the transmitter using COM and SKP symbols. It also tracks symbol lock and presents a registered valid/ready stream downstream.

## Interface
- SEED, 16'hFFFF, LFSR value loaded on reset and on every COM.
- COM_SYM, 8'hBC, K28.5 code byte.
- SKP_SYM, 8'h1C, K28.0 code byte.
- clk_i  input  1  clock. One clock domain.
- rst_ni  input  1  reset. Asynchronous, active-low.
- data_i  input  8  decoded symbol byte.
- k_i  input  1  1 = control (K) symbol.
- valid_i  input  1  input symbol valid.
- ready_o  output  1  block can accept a symbol this cycle.
- disable_i  input  1  scrambling disabled (link training/loopback). Data passes unmodified.
- resync_i  input  1  single-cycle pulse forcing loss of lock.
- data_o  output  8  descrambled byte.
- k_o  output  1  K flag, forwarded.
- valid_o  output  1  output valid.
- ready_i  input  1  downstream accepts.
- sync_o  output  1  1 = LFSR aligned (COM seen since reset/resync).
- skp_cnt_o  output  8  count of SKP symbols accepted while in SYNC. Wraps at 255->0.

## Operation
- Accept: a symbol is accepted on a rising edge with valid_i && ready_o.
- ready_o = !valid_o || ready_i. This is combinational and gives one-entry output buffering.
- LFSR state lfsr[15:0], Galois form. One step computes:
  - n[0]=q[15]
  - n[1]=q[0], n[2]=q[1]
  - n[3]=q[2]^q[15], n[4]=q[3]^q[15], n[5]=q[4]^q[15]
  - n[15:6]=q[14:5]
- Byte scrambling: for i = 0..7 (LSB first), key[i] = q[15] before step i; then the LFSR steps once. Each byte therefore advances the LFSR 8 steps.
- FSM, two states:
  - UNSYNC:
    - Every accepted symbol is dropped (no valid_o) except COM.
    - Accepted COM (k_i=1, data_i=COM_SYM): forwarded unchanged, lfsr<=SEED, go to SYNC, sync_o<=1.
  - SYNC, per accepted symbol:
    - COM: forwarded unchanged; lfsr<=SEED.
    - SKP (K): forwarded unchanged; LFSR does not advance; skp_cnt_o increments.
    - Other K symbol: forwarded unchanged; LFSR advances 8 steps.
    - D symbol: data_o = data_i ^ key (or data_i if disable_i=1); LFSR advances 8 steps in both cases.
- resync_i=1 forces UNSYNC next cycle. It takes priority over a COM accepted in the same cycle. The pending output register is unaffected. skp_cnt_o holds its value.
- disable_i affects only the XOR. LFSR tracking and the FSM are unchanged.
- Reset (asynchronous, any time including mid-stream): state=UNSYNC, lfsr=SEED, valid_o=0, data_o=0, k_o=0, sync_o=0, skp_cnt_o=0.

## Timing
- Latency: 1 cycle from acceptance to valid_o (registered output).
- Throughput: 1 symbol/cycle while ready_i=1.
- Backpressure: while valid_o && !ready_i, data_o, k_o and valid_o hold stable. ready_o=0 and the LFSR holds.
- Simultaneous output pop and input accept: the output register reloads in the same cycle, with no bubble.
- sync_o rises the cycle the first COM appears on valid_o. It falls the cycle after a resync_i pulse.
- skp_cnt_o updates the cycle after the SKP is accepted.
- All outputs are registered. No combinational path from data_i to data_o. The only combinational path from ready_i is to ready_o.

## Test plan
- Reset then COM then 16 D bytes of 0x00 with ready_i=1 -> output COM, then FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D. sync_o=1 from the COM output cycle.
- Same stream with SKP inserted after byte 3 -> SKP forwarded and skp_cnt_o=1. D bytes are identical to the previous sequence (LFSR paused).
- D bytes before any COM -> no valid_o and sync_o=0. The first COM is forwarded, and the following 0x00 -> 0xFF.
- ready_i=0 for 3 cycles mid-stream -> ready_o=0, data_o held. After release, the sequence continues with no skipped or duplicated bytes.
- disable_i=1 with input 0x5A stream after COM -> output 0x5A. When disable_i drops, the next 0x00 yields the key for its position (LFSR kept advancing).
- resync_i pulse, or rst_ni low mid-stream -> sync_o=0 and subsequent D bytes dropped until the next COM. After reset, all outputs are 0.
